// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq_ctrl controller: opcodes, FSM states,
// flag bit positions and the opcode decoder.
package alu_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam int FLG_Z = 2;
    localparam int FLG_S = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        B_ZERO = 2'd0,
        B_RS   = 2'd1,
        B_IMM  = 2'd2
    } bsrc_t;

    typedef struct packed {
        logic  a_rd;       // A operand is regs[rd] (else 0)
        bsrc_t b_src;
        logic  add_sub_n;
        logic  wr;
        logic  upd;
        logic  err;
    } dec_t;

    function automatic dec_t op_decode(input logic [2:0] op);
        dec_t d;
        d = '{a_rd: 1'b0, b_src: B_ZERO, add_sub_n: 1'b1, wr: 1'b0, upd: 1'b0, err: 1'b0};
        case (op)
            OP_NOP:  ;
            OP_LDI:  d = '{a_rd: 1'b0, b_src: B_IMM, add_sub_n: 1'b1, wr: 1'b1, upd: 1'b1, err: 1'b0};
            OP_ADD:  d = '{a_rd: 1'b1, b_src: B_RS,  add_sub_n: 1'b1, wr: 1'b1, upd: 1'b1, err: 1'b0};
            OP_SUB:  d = '{a_rd: 1'b1, b_src: B_RS,  add_sub_n: 1'b0, wr: 1'b1, upd: 1'b1, err: 1'b0};
            OP_ADDI: d = '{a_rd: 1'b1, b_src: B_IMM, add_sub_n: 1'b1, wr: 1'b1, upd: 1'b1, err: 1'b0};
            OP_CMP:  d = '{a_rd: 1'b1, b_src: B_RS,  add_sub_n: 1'b0, wr: 1'b0, upd: 1'b1, err: 1'b0};
            OP_MOV:  d = '{a_rd: 1'b0, b_src: B_RS,  add_sub_n: 1'b1, wr: 1'b1, upd: 1'b1, err: 1'b0};
            default: d.err = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NUM_REGS x 8 register file: two combinational read ports, one synchronous
// write port, synchronous clear on rst.
module alu_seq_regfile #(
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [7:0]        rdata_a,
    output logic [7:0]        rdata_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [7:0]        wdata
);

    logic [7:0] regs [NUM_REGS];

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-state sequencer driving an external combinational add/sub ALU.
// Optional ALU_SAT_EN: saturate overflowing results on writeback.
import alu_seq_pkg::*;

module alu_seq_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs,
    input  logic [7:0]        cmd_imm,
    output logic [7:0]        alu_first,
    output logic [7:0]        alu_second,
    output logic              alu_add_sub_n,
    input  logic [7:0]        alu_result,
    input  logic              alu_z,
    input  logic              alu_s,
    input  logic              alu_v,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic [2:0]        rsp_flags,
    output logic              rsp_err
);

    state_t            state;
    logic [2:0]        op_q;
    logic [REG_AW-1:0] rd_q, rs_q;
    logic [7:0]        imm_q;
    logic [7:0]        a_q, b_q, res_q;
    logic              z_q, s_q, v_q;
    logic [2:0]        flags_q;
    logic [7:0]        rd_val, rs_val;
    logic [7:0]        a_nxt, b_nxt;
    logic [7:0]        wb_data;
    logic [2:0]        wb_flags;
    dec_t              dec;

    assign dec       = op_decode(op_q);
    assign cmd_ready = (state == S_IDLE) && !rst;

    alu_seq_regfile #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rd_q),
        .raddr_b (rs_q),
        .rdata_a (rd_val),
        .rdata_b (rs_val),
        .we      ((state == S_WB) && dec.wr),
        .waddr   (rd_q),
        .wdata   (wb_data)
    );

    always_comb begin
        a_nxt = dec.a_rd ? rd_val : '0;
        case (dec.b_src)
            B_RS:    b_nxt = rs_val;
            B_IMM:   b_nxt = imm_q;
            default: b_nxt = '0;
        endcase
    end

    always_comb begin
        wb_data         = res_q;
        wb_flags        = '0;
        wb_flags[FLG_Z] = z_q;
        wb_flags[FLG_S] = s_q;
        wb_flags[FLG_V] = v_q;
`ifdef ALU_SAT_EN
        // Overflow direction follows the sign of A: positive A overflows upward.
        if (v_q) begin
            wb_data         = a_q[7] ? 8'h80 : 8'h7F;
            wb_flags[FLG_Z] = (wb_data == 8'h00);
            wb_flags[FLG_S] = wb_data[7];
            wb_flags[FLG_V] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            op_q          <= OP_NOP;
            rd_q          <= '0;
            rs_q          <= '0;
            imm_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            z_q           <= 1'b0;
            s_q           <= 1'b0;
            v_q           <= 1'b0;
            flags_q       <= '0;
            alu_first     <= '0;
            alu_second    <= '0;
            alu_add_sub_n <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_flags     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        rs_q  <= cmd_rs;
                        imm_q <= cmd_imm;
                        state <= S_READ;
                    end
                end
                // ALU ports are loaded together with A/B so they are stable for all of EXEC.
                S_READ: begin
                    a_q           <= a_nxt;
                    b_q           <= b_nxt;
                    alu_first     <= a_nxt;
                    alu_second    <= b_nxt;
                    alu_add_sub_n <= dec.add_sub_n;
                    state         <= S_EXEC;
                end
                S_EXEC: begin
                    res_q <= alu_result;
                    z_q   <= alu_z;
                    s_q   <= alu_s;
                    v_q   <= alu_v;
                    state <= S_WB;
                end
                S_WB: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= dec.err;
                    rsp_data  <= dec.err ? 8'h00 : wb_data;
                    rsp_flags <= dec.upd ? wb_flags : flags_q;
                    if (dec.upd) flags_q <= wb_flags;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Table-driven bench for alu_seq_ctrl with a behavioural model of the external ALU.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_rd = '0, cmd_rs = '0;
    logic [7:0] cmd_imm = '0;
    logic [7:0] alu_first, alu_second, alu_result;
    logic       alu_add_sub_n, alu_z, alu_s, alu_v;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_data;
    logic [2:0] rsp_flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.NUM_REGS(4), .REG_AW(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
        .alu_first(alu_first), .alu_second(alu_second), .alu_add_sub_n(alu_add_sub_n),
        .alu_result(alu_result), .alu_z(alu_z), .alu_s(alu_s), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // External combinational ALU
    always_comb begin
        alu_result = alu_add_sub_n ? (alu_first + alu_second) : (alu_first - alu_second);
        alu_z = (alu_result == 8'h00);
        alu_s = alu_result[7];
        if (alu_add_sub_n)
            alu_v = (alu_first[7] == alu_second[7]) && (alu_result[7] != alu_first[7]);
        else
            alu_v = (alu_first[7] != alu_second[7]) && (alu_result[7] != alu_first[7]);
    end

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic [7:0] data;
        logic [2:0] flags;
        logic       err;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm, output logic [7:0] d, output logic [2:0] f,
                         output logic e, output int lat, output bit rdy_ok);
        int w;
        w = 0;
        rdy_ok = 1'b1;
        lat = 0;
        d = '0;
        f = '0;
        e = 1'b0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_rd = rd;
        cmd_rs = rs;
        cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (rsp_valid) begin
                lat = k;
                d = rsp_data;
                f = rsp_flags;
                e = rsp_err;
                if (!cmd_ready) rdy_ok = 1'b0;
                break;
            end
            if (cmd_ready) rdy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [2:0] f;
        logic       e;
        int         lat;
        bit         rdy_ok;
        int         seen;

        vecs[0]  = '{OP_LDI,  2'd0, 2'd0, 8'h05, 8'h05, 3'b000, 1'b0};
        vecs[1]  = '{OP_LDI,  2'd1, 2'd0, 8'h64, 8'h64, 3'b000, 1'b0};
        vecs[2]  = '{OP_LDI,  2'd2, 2'd0, 8'h32, 8'h32, 3'b000, 1'b0};
`ifdef ALU_SAT_EN
        vecs[3]  = '{OP_ADD,  2'd1, 2'd2, 8'h00, 8'h7F, 3'b001, 1'b0};
`else
        vecs[3]  = '{OP_ADD,  2'd1, 2'd2, 8'h00, 8'h96, 3'b011, 1'b0};
`endif
        vecs[4]  = '{OP_LDI,  2'd0, 2'd0, 8'h07, 8'h07, 3'b000, 1'b0};
        vecs[5]  = '{OP_CMP,  2'd0, 2'd0, 8'h00, 8'h00, 3'b100, 1'b0};
        vecs[6]  = '{OP_MOV,  2'd3, 2'd0, 8'h00, 8'h07, 3'b000, 1'b0};
        vecs[7]  = '{OP_SUB,  2'd3, 2'd3, 8'h00, 8'h00, 3'b100, 1'b0};
        vecs[8]  = '{OP_ILL,  2'd0, 2'd1, 8'h3C, 8'h00, 3'b100, 1'b1};
        vecs[9]  = '{OP_NOP,  2'd0, 2'd0, 8'h00, 8'h00, 3'b100, 1'b0};
        vecs[10] = '{OP_MOV,  2'd1, 2'd0, 8'h00, 8'h07, 3'b000, 1'b0};
        vecs[11] = '{OP_MOV,  2'd2, 2'd3, 8'h00, 8'h00, 3'b100, 1'b0};
        vecs[12] = '{OP_ADDI, 2'd0, 2'd0, 8'hF8, 8'hFF, 3'b010, 1'b0};
        vecs[13] = '{OP_LDI,  2'd1, 2'd0, 8'h80, 8'h80, 3'b010, 1'b0};
        vecs[14] = '{OP_LDI,  2'd2, 2'd0, 8'h01, 8'h01, 3'b000, 1'b0};
`ifdef ALU_SAT_EN
        vecs[15] = '{OP_SUB,  2'd1, 2'd2, 8'h00, 8'h80, 3'b011, 1'b0};
        vecs[16] = '{OP_MOV,  2'd0, 2'd1, 8'h00, 8'h80, 3'b010, 1'b0};
`else
        vecs[15] = '{OP_SUB,  2'd1, 2'd2, 8'h00, 8'h7F, 3'b001, 1'b0};
        vecs[16] = '{OP_MOV,  2'd0, 2'd1, 8'h00, 8'h7F, 3'b000, 1'b0};
`endif
        vecs[17] = '{OP_LDI,  2'd1, 2'd0, 8'h03, 8'h03, 3'b000, 1'b0};
        vecs[18] = '{OP_ADD,  2'd1, 2'd1, 8'h00, 8'h06, 3'b000, 1'b0};
        vecs[19] = '{OP_CMP,  2'd1, 2'd2, 8'h00, 8'h05, 3'b000, 1'b0};
        vecs[20] = '{OP_MOV,  2'd0, 2'd1, 8'h00, 8'h06, 3'b000, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset alu_first", alu_first, 0);
        chk("reset alu_second", alu_second, 0);
        chk("reset alu_add_sub_n", alu_add_sub_n, 1);
        rst = 1'b0;
        #1;
        chk("ready after reset", cmd_ready, 1);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, d, f, e, lat, rdy_ok);
            chk($sformatf("vec%0d latency", i), lat, 4);
            chk($sformatf("vec%0d ready", i), rdy_ok, 1);
            chk($sformatf("vec%0d data", i), d, vecs[i].data);
            chk($sformatf("vec%0d flags", i), f, vecs[i].flags);
            chk($sformatf("vec%0d err", i), e, vecs[i].err);
        end

        // Command held valid with changing fields while busy: only the accepted one runs
        @(negedge clk);
        chk("hold idle ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = OP_LDI;
        cmd_rd = 2'd3;
        cmd_rs = 2'd0;
        cmd_imm = 8'h55;
        @(negedge clk);
        seen = 0;
        for (int k = 1; k <= 10; k++) begin
            if (rsp_valid) begin
                seen = k;
                cmd_valid = 1'b0;
                break;
            end
            cmd_op = 3'(k + 1);
            cmd_rd = 2'(k);
            cmd_rs = 2'(k + 2);
            cmd_imm = 8'(k * 37);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("hold latency", seen, 4);
        chk("hold data", rsp_data, 8'h55);
        chk("hold err", rsp_err, 0);
        issue(OP_MOV, 2'd0, 2'd3, 8'h00, d, f, e, lat, rdy_ok);
        chk("hold readback", d, 8'h55);
        chk("hold readback flags", f, 3'b000);

        // Reset during EXEC of LDI r2,#9
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = OP_LDI;
        cmd_rd = 2'd2;
        cmd_imm = 8'h09;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready after rst", cmd_ready, 1);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no rsp after rst", seen, 0);
        issue(OP_MOV, 2'd0, 2'd2, 8'h00, d, f, e, lat, rdy_ok);
        chk("r2 cleared", d, 8'h00);
        chk("r2 cleared flags", f, 3'b100);
        issue(OP_MOV, 2'd0, 2'd1, 8'h00, d, f, e, lat, rdy_ok);
        chk("r1 cleared", d, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
